alu181_nibble_sequencer: RTL

//  Sequences one combinational 4-bit 74181-style ALU slice to run WIDTH-bit operations, one nibble per cycle, LSB nibble first.

---
 rtl/alu181_nibble_sequencer.sv | 130 +++++++++++++
 1 files changed

// File: rtl/alu181_nibble_sequencer.sv
// Runs WIDTH-bit 74181 operations through one external 4-bit slice, one nibble
// per cycle (LSB first), with valid/ready handshakes on both request and result.
module alu181_nibble_sequencer #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [3:0]       in_s,
  input  logic             in_m,
  input  logic             in_cnb,
  output logic [3:0]       alu_a,
  output logic [3:0]       alu_b,
  output logic [3:0]       alu_s,
  output logic             alu_m,
  output logic             alu_cnb,
  input  logic [3:0]       alu_f,
  input  logic             alu_cn4b,
  input  logic             alu_aeb,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_f,
  output logic             out_cn4b,
  output logic             out_aeb,
  output logic             busy
);

  localparam int NIB = WIDTH / 4;
  localparam int IW  = (NIB > 1) ? $clog2(NIB) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state_r;
  state_t          state_s;
  logic [IW-1:0]   idx_r;
  logic [IW-1:0]   idx_nxt_s;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic            aeb_r;
  logic            accept_s;
  logic            last_s;

  assign accept_s  = in_valid && (state_r == IDLE);
  assign last_s    = (idx_r == IW'(NIB - 1));
  assign idx_nxt_s = idx_r + IW'(1);

  assign in_ready  = (state_r == IDLE);
  assign out_valid = (state_r == DONE);
  assign busy      = (state_r == RUN) || (state_r == DONE);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state decode
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) state_s = RUN;
        else          state_s = IDLE;
      end
      RUN: begin
        if (last_s) state_s = DONE;
        else        state_s = RUN;
      end
      DONE: begin
        if (out_ready) state_s = IDLE;
        else           state_s = DONE;
      end
      default: state_s = IDLE;
    endcase
  end

  // Operand latch, slice drive, carry/aeb chaining and result assembly.
  // The slice drive registers are preloaded with the next nibble so that the
  // slice sees nibble idx for the whole cycle and holds it once RUN ends.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_r    <= '0;
      a_r      <= '0;
      b_r      <= '0;
      aeb_r    <= 1'b1;
      alu_a    <= 4'h0;
      alu_b    <= 4'h0;
      alu_s    <= 4'h0;
      alu_m    <= 1'b0;
      alu_cnb  <= 1'b1;
      out_f    <= '0;
      out_cn4b <= 1'b1;
      out_aeb  <= 1'b1;
    end else if (accept_s) begin
      idx_r   <= '0;
      a_r     <= in_a;
      b_r     <= in_b;
      aeb_r   <= 1'b1;
      alu_a   <= in_a[3:0];
      alu_b   <= in_b[3:0];
      alu_s   <= in_s;
      alu_m   <= in_m;
      alu_cnb <= in_cnb;
    end else if (state_r == RUN) begin
      out_f[4*idx_r +: 4] <= alu_f;
      aeb_r               <= aeb_r & alu_aeb;
      if (last_s) begin
        idx_r    <= '0;
        out_cn4b <= alu_cn4b;
        out_aeb  <= aeb_r & alu_aeb;
      end else begin
        idx_r   <= idx_nxt_s;
        alu_a   <= a_r[4*idx_nxt_s +: 4];
        alu_b   <= b_r[4*idx_nxt_s +: 4];
        alu_cnb <= alu_cn4b;
      end
    end
  end

endmodule
